// File: rtl/sprite_tile_fetcher_if.sv
// ---------------------------------------------------------------------------
// sprite_tile_fetcher_if
// Bundles the three buses of the sprite tile fetcher:
//   command port : cmd_valid/cmd_ready with cmd_x, cmd_addr, cmd_groups, cmd_hflip
//   VRAM port    : vram_req/vram_addr out, vram_ack/vram_rdata in
//   doubler port : tile_pixels, tile_valid_mask, lb_x, plus busy status
// Modports:
//   slave  - the fetcher itself
//   master - whoever feeds commands and VRAM data and consumes tile groups
// ---------------------------------------------------------------------------
interface sprite_tile_fetcher_if #(
  parameter int ADDR_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [11:0]       cmd_x;
  logic [ADDR_W-1:0] cmd_addr;
  logic [5:0]        cmd_groups;
  logic              cmd_hflip;
  logic              vram_req;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_ack;
  logic [35:0]       vram_rdata;
  logic [35:0]       tile_pixels;
  logic [3:0]        tile_valid_mask;
  logic [11:0]       lb_x;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_x, cmd_addr, cmd_groups, cmd_hflip, vram_ack, vram_rdata,
    output cmd_ready, vram_req, vram_addr, tile_pixels, tile_valid_mask, lb_x, busy
  );

  modport master (
    output cmd_valid, cmd_x, cmd_addr, cmd_groups, cmd_hflip, vram_ack, vram_rdata,
    input  cmd_ready, vram_req, vram_addr, tile_pixels, tile_valid_mask, lb_x, busy
  );
endinterface

// File: rtl/sprite_tile_fetcher.sv
// ---------------------------------------------------------------------------
// sprite_tile_fetcher
// Turns one sprite-row command into a stream of 4-pixel groups for the pixel
// doubler. Words are fetched from VRAM over a req/ack port; every acked word
// is presented one cycle later with a per-pixel valid mask (transparent
// pixels invalid). Cycles without data present an all-zero group whose lb_x
// is the x of the next group. A one-cycle FLUSH after each sprite guarantees
// a zero-mask cycle between sprites.
//
// Ports:
//   clk_draw    - draw clock, all logic on rising edge
//   rst_draw_n  - asynchronous active-low reset
//   bus         - sprite_tile_fetcher_if.slave (command, VRAM, doubler buses)
//
// Optional feature macro: SPRITE_HFLIP_EN
//   Defined: cmd_hflip latched on accept; addresses run downward from
//   cmd_addr + cmd_groups - 1 and pixels are reversed within each word.
//   Undefined: cmd_hflip is ignored.
// ---------------------------------------------------------------------------
module sprite_tile_fetcher #(
  parameter int         ADDR_W      = 16,
  parameter logic [8:0] TRANSPARENT = 9'h000
) (
  input  logic                 clk_draw,
  input  logic                 rst_draw_n,
  sprite_tile_fetcher_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            state_r;
  logic [5:0]        remaining_r;
  logic [11:0]       x_next_r;
  logic [ADDR_W-1:0] addr_r;
  logic              req_r;
  logic [35:0]       pix_r;
  logic [3:0]        mask_r;
  logic [11:0]       lb_x_r;

  logic [35:0]       word_s;
  logic [ADDR_W-1:0] start_addr_s;
  logic [ADDR_W-1:0] next_addr_s;

  // One valid bit per 9-bit pixel: set unless the pixel is the transparent code.
  function automatic logic [3:0] pixel_mask(input logic [35:0] w);
    logic [3:0] m;
    m = 4'h0;
    for (int i = 0; i < 4; i++) begin
      m[i] = (w[9*i +: 9] != TRANSPARENT);
    end
    return m;
  endfunction

`ifdef SPRITE_HFLIP_EN
  logic hflip_r;

  // Swap pixel order inside a word: output pixel i takes input pixel 3-i.
  function automatic logic [35:0] reverse_pixels(input logic [35:0] w);
    logic [35:0] r;
    r = 36'h0;
    for (int i = 0; i < 4; i++) begin
      r[9*i +: 9] = w[9*(3-i) +: 9];
    end
    return r;
  endfunction

  // Word ordering and address stepping depend on the latched flip flag.
  always_comb begin
    if (hflip_r) begin
      word_s      = reverse_pixels(bus.vram_rdata);
      next_addr_s = addr_r - ADDR_W'(1'b1);
    end else begin
      word_s      = bus.vram_rdata;
      next_addr_s = addr_r + ADDR_W'(1'b1);
    end
    if (bus.cmd_hflip) begin
      start_addr_s = bus.cmd_addr + ADDR_W'(bus.cmd_groups) - ADDR_W'(1'b1);
    end else begin
      start_addr_s = bus.cmd_addr;
    end
  end

  // Flip flag captured with the command so it holds for the whole sprite.
  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      hflip_r <= 1'b0;
    end else if (state_r == ST_IDLE && bus.cmd_valid) begin
      hflip_r <= bus.cmd_hflip;
    end else begin
      hflip_r <= hflip_r;
    end
  end
`else
  logic unused_hflip_s;
  assign unused_hflip_s = bus.cmd_hflip;

  // Without flip support words pass straight through and addresses count up.
  always_comb begin
    word_s       = bus.vram_rdata;
    next_addr_s  = addr_r + ADDR_W'(1'b1);
    start_addr_s = bus.cmd_addr;
  end
`endif

  // Main FSM: command accept, VRAM fetch sequencing and registered outputs.
  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      state_r     <= ST_IDLE;
      remaining_r <= 6'd0;
      x_next_r    <= 12'd0;
      addr_r      <= '0;
      req_r       <= 1'b0;
      pix_r       <= 36'h0;
      mask_r      <= 4'h0;
      lb_x_r      <= 12'd0;
    end else begin
      // lb_x always reports where the next group will land, data or not.
      lb_x_r <= x_next_r;
      case (state_r)
        ST_IDLE: begin
          pix_r  <= 36'h0;
          mask_r <= 4'h0;
          if (bus.cmd_valid) begin
            x_next_r <= bus.cmd_x;
            if (bus.cmd_groups != 6'd0) begin
              state_r     <= ST_FETCH;
              req_r       <= 1'b1;
              remaining_r <= bus.cmd_groups;
              addr_r      <= start_addr_s;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (bus.vram_ack) begin
            pix_r       <= word_s;
            mask_r      <= pixel_mask(word_s);
            x_next_r    <= x_next_r + 12'd8;
            remaining_r <= remaining_r - 6'd1;
            addr_r      <= next_addr_s;
            if (remaining_r == 6'd1) begin
              // Last word: request drops with the ack so no extra word is read.
              state_r <= ST_FLUSH;
              req_r   <= 1'b0;
            end else begin
              state_r <= ST_FETCH;
            end
          end else begin
            pix_r  <= 36'h0;
            mask_r <= 4'h0;
          end
        end
        ST_FLUSH: begin
          pix_r   <= 36'h0;
          mask_r  <= 4'h0;
          state_r <= ST_IDLE;
        end
        default: begin
          pix_r   <= 36'h0;
          mask_r  <= 4'h0;
          req_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready       = (state_r == ST_IDLE);
  assign bus.busy            = (state_r != ST_IDLE);
  assign bus.vram_req        = req_r;
  assign bus.vram_addr       = addr_r;
  assign bus.tile_pixels     = pix_r;
  assign bus.tile_valid_mask = mask_r;
  assign bus.lb_x            = lb_x_r;

endmodule

// File: tb/tb_sprite_tile_fetcher.sv
// ---------------------------------------------------------------------------
// tb_sprite_tile_fetcher
// Scoreboard bench: the command driver pushes every group it expects into a
// queue; a negedge monitor pops one entry per acked word and compares the
// address, pixels, mask and lb_x, and checks idle/stall/flush cycles.
// VRAM contents come from a bench-side table addressed by a hash of the
// word address, so expected data is known when the command is issued.
// ---------------------------------------------------------------------------
module tb_sprite_tile_fetcher;

  logic clk_draw   = 1'b0;
  logic rst_draw_n = 1'b0;

  always #5 clk_draw = ~clk_draw;

  sprite_tile_fetcher_if #(.ADDR_W(16)) bus ();

  sprite_tile_fetcher #(
    .ADDR_W      (16),
    .TRANSPARENT (9'h000)
  ) dut (
    .clk_draw   (clk_draw),
    .rst_draw_n (rst_draw_n),
    .bus        (bus)
  );

`ifdef SPRITE_HFLIP_EN
  localparam bit HFLIP_EN = 1'b1;
`else
  localparam bit HFLIP_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] addr;
    logic [35:0] pix;
    logic [3:0]  mask;
    logic [11:0] x;
  } exp_t;

  exp_t        exp_q[$];
  logic [35:0] mem [256];
  int          ack_pct = 100;
  int          checks  = 0;
  int          errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [35:0] vram_word(input logic [15:0] a);
    return mem[a[7:0] ^ a[15:8]];
  endfunction

  // Drive point: just after the falling edge.
  task automatic step();
    @(negedge clk_draw);
    #1;
  endtask

  // Offer one command and record the groups it should produce.
  task automatic issue(input logic [11:0] x, input logic [15:0] a, input logic [5:0] g,
                       input logic hf);
    int          t;
    bit          flip;
    logic [15:0] wa;
    logic [35:0] w;
    exp_t        e;
    t = 0;
    while (!bus.cmd_ready && t < 4000) begin
      step();
      t++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_wait actual=busy required=ready");
    end
    flip           = hf && HFLIP_EN;
    bus.cmd_valid  = 1'b1;
    bus.cmd_x      = x;
    bus.cmd_addr   = a;
    bus.cmd_groups = g;
    bus.cmd_hflip  = hf;
    for (int i = 0; i < g; i++) begin
      if (flip) wa = a + 16'(g) - 16'd1 - 16'(i);
      else      wa = a + 16'(i);
      w = vram_word(wa);
      e.addr = wa;
      for (int p = 0; p < 4; p++) begin
        e.pix[9*p +: 9] = flip ? w[9*(3-p) +: 9] : w[9*p +: 9];
        e.mask[p]       = (e.pix[9*p +: 9] != 9'h000);
      end
      e.x = x + 12'(8 * i);
      exp_q.push_back(e);
    end
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(bus.cmd_ready && exp_q.size() == 0) && t < 4000) begin
      step();
      t++;
    end
    check("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  // VRAM responder: random acks; data only meaningful on acked cycles.
  always @(negedge clk_draw) begin
    #1;
    bus.vram_ack = ($urandom_range(99) < ack_pct);
    if (bus.vram_ack) bus.vram_rdata = vram_word(bus.vram_addr);
    else              bus.vram_rdata = {$urandom_range(15), $urandom};
  end

  // Monitor state: x of the next group and bus values seen before the last edge.
  logic [11:0] model_x;
  logic        prev_req, prev_ready;
  logic [15:0] prev_addr;

  always @(negedge clk_draw) begin
    bit   got, emptied, accepted;
    exp_t e;
    if (!rst_draw_n) begin
      check("rst_ready", 64'(bus.cmd_ready), 64'd1);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_req", 64'(bus.vram_req), 64'd0);
      check("rst_addr", 64'(bus.vram_addr), 64'd0);
      check("rst_pix", 64'(bus.tile_pixels), 64'd0);
      check("rst_mask", 64'(bus.tile_valid_mask), 64'd0);
      check("rst_lbx", 64'(bus.lb_x), 64'd0);
      exp_q.delete();
      model_x    = 12'd0;
      prev_req   = 1'b0;
      prev_ready = 1'b1;
      prev_addr  = 16'd0;
    end else begin
      got      = prev_req && bus.vram_ack;
      accepted = bus.cmd_valid && prev_ready;
      emptied  = 1'b0;
      if (got) begin
        if (exp_q.size() == 0) begin
          check("unexpected_data", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("addr", 64'(prev_addr), 64'(e.addr));
          check("pixels", 64'(bus.tile_pixels), 64'(e.pix));
          check("mask", 64'(bus.tile_valid_mask), 64'(e.mask));
          check("lbx_data", 64'(bus.lb_x), 64'(e.x));
          model_x = e.x + 12'd8;
          emptied = (exp_q.size() == 0);
        end
      end else begin
        check("idle_pix", 64'(bus.tile_pixels), 64'd0);
        check("idle_mask", 64'(bus.tile_valid_mask), 64'd0);
        check("lbx_idle", 64'(bus.lb_x), 64'(model_x));
        if (accepted) model_x = bus.cmd_x;
      end
      // After the last word the block sits one cycle in FLUSH before ready.
      check("ready", 64'(bus.cmd_ready), 64'(!emptied && exp_q.size() == 0));
      check("busy", 64'(bus.busy), 64'(emptied || exp_q.size() != 0));
      check("req", 64'(bus.vram_req), 64'(exp_q.size() != 0));
      prev_req   = bus.vram_req;
      prev_ready = bus.cmd_ready;
      prev_addr  = bus.vram_addr;
    end
  end

  initial begin
    logic [15:0] a;
    logic [5:0]  g;
    int          r;
    for (int i = 0; i < 256; i++) begin
      for (int p = 0; p < 4; p++) begin
        mem[i][9*p +: 9] = ($urandom_range(3) == 0) ? 9'h000 : 9'($urandom);
      end
    end
    // Word at 0x0100 carries the transparent/opaque pattern 0101.
    mem[8'h01] = {9'h000, 9'h1FF, 9'h000, 9'h001};
    bus.cmd_valid  = 1'b0;
    bus.cmd_x      = 12'd0;
    bus.cmd_addr   = 16'd0;
    bus.cmd_groups = 6'd0;
    bus.cmd_hflip  = 1'b0;
    bus.vram_ack   = 1'b0;
    bus.vram_rdata = 36'h0;
    repeat (3) step();
    rst_draw_n = 1'b1;
    step();

    ack_pct = 100;
    issue(12'h005, 16'h0100, 6'd3, 1'b0);
    issue(12'hFFC, 16'h0300, 6'd2, 1'b0);
    issue(12'h123, 16'h0400, 6'd0, 1'b0);
    issue(12'h010, 16'hFFFF, 6'd3, 1'b0);
    issue(12'h040, 16'h0200, 6'd2, 1'b1);
    wait_idle();

    ack_pct = 35;
    issue(12'h080, 16'h0500, 6'd2, 1'b0);
    issue(12'h090, 16'h0001, 6'd4, 1'b1);
    wait_idle();

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(2);
      ack_pct = (r == 0) ? 100 : ((r == 1) ? 70 : 30);
      r = $urandom_range(9);
      g = (r == 9) ? 6'($urandom_range(63, 20)) : 6'(r);
      a = ($urandom_range(3) == 0) ? 16'hFFFC + 16'($urandom_range(3)) : 16'($urandom);
      issue(12'($urandom), a, g, 1'($urandom));
      if ($urandom_range(3) == 0) repeat ($urandom_range(3)) step();
    end
    wait_idle();

    // Reset in the middle of a long sprite, then recover.
    ack_pct = 50;
    issue(12'h200, 16'h0800, 6'd30, 1'b0);
    repeat (6) step();
    rst_draw_n = 1'b0;
    step();
    step();
    rst_draw_n = 1'b1;
    step();
    issue(12'h300, 16'h0900, 6'd5, 1'b1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
